// File: rtl/projectile_slot_arbiter.sv
// Frame-synchronous arbiter sharing a pool of projectile slots between the tank and the monsters.
// Build option: define ROUND_ROBIN_EN for round-robin monster selection; undefined gives fixed priority.
module projectile_slot_arbiter #(
    parameter int NUM_SLOTS    = 4,
    parameter int NUM_MONSTERS = 8,
    parameter int MAX_LIFE     = 240
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_frame_tick,
    input  logic                         i_enable,
    input  logic                         i_clear,
    input  logic                         i_tank_req,
    input  logic [NUM_MONSTERS-1:0]      i_mon_req,
    input  logic [NUM_SLOTS-1:0]         i_slot_release,
    output logic                         o_tank_gnt,
    output logic [NUM_MONSTERS-1:0]      o_mon_gnt,
    output logic [$clog2(NUM_SLOTS)-1:0] o_gnt_slot,
    output logic [NUM_SLOTS-1:0]         o_slot_busy,
    output logic [NUM_SLOTS-1:0]         o_slot_tank,
    output logic [NUM_SLOTS-1:0]         o_slot_expire
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int MON_W  = $clog2(NUM_MONSTERS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t                  r_state;
    logic                    r_tank_gnt;
    logic [NUM_MONSTERS-1:0] r_mon_gnt;
    logic [SLOT_W-1:0]       r_gnt_slot;
    logic [NUM_SLOTS-1:0]    r_slot_busy;
    logic [NUM_SLOTS-1:0]    r_slot_tank;
    logic [NUM_SLOTS-1:0]    r_slot_expire;
    logic [7:0]              r_life [NUM_SLOTS];
`ifdef ROUND_ROBIN_EN
    logic [MON_W-1:0]        r_rr_ptr;
    int                      w_cand;
`endif

    logic              w_tick_arb;
    logic              w_tick_age;
    logic              w_free_found;
    logic [SLOT_W-1:0] w_free_idx;
    logic              w_tank_out;
    logic              w_tank_elig;
    logic              w_mon_room;
    logic              w_mon_found;
    logic [MON_W-1:0]  w_mon_idx;
    logic              w_do_tank;
    logic              w_do_mon;

    assign w_tick_arb  = (r_state == ST_RUN) && i_frame_tick;
    assign w_tick_age  = (r_state != ST_IDLE) && i_frame_tick;
    assign w_tank_out  = |(r_slot_busy & r_slot_tank);
    assign w_tank_elig = i_tank_req && !w_tank_out;
    // One slot stays reserved for the tank, so monsters may hold at most NUM_SLOTS-1.
    assign w_mon_room  = ($countones(r_slot_busy & ~r_slot_tank) < NUM_SLOTS - 1);

    // Lowest-index free slot; only the registered busy bits count, so a
    // slot released during the decision cycle is not reused yet.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!r_slot_busy[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = SLOT_W'(i);
            end
        end
    end

`ifdef ROUND_ROBIN_EN
    // Search starts one past the last monster granted and wraps around.
    always_comb begin
        w_mon_found = 1'b0;
        w_mon_idx   = '0;
        w_cand      = 0;
        for (int k = 1; k <= NUM_MONSTERS; k++) begin
            w_cand = (int'(r_rr_ptr) + k) % NUM_MONSTERS;
            if (!w_mon_found && i_mon_req[MON_W'(w_cand)]) begin
                w_mon_found = 1'b1;
                w_mon_idx   = MON_W'(w_cand);
            end
        end
    end
`else
    always_comb begin
        w_mon_found = 1'b0;
        w_mon_idx   = '0;
        for (int k = NUM_MONSTERS - 1; k >= 0; k--) begin
            if (i_mon_req[k]) begin
                w_mon_found = 1'b1;
                w_mon_idx   = MON_W'(k);
            end
        end
    end
`endif

    // Tank beats every monster; clear suppresses any grant in its cycle.
    assign w_do_tank = w_tick_arb && !i_clear && w_tank_elig && w_free_found;
    assign w_do_mon  = w_tick_arb && !i_clear && !w_tank_elig && w_mon_found &&
                       w_mon_room && w_free_found;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: sequential state uses non-blocking assignments; the small life array is reset too.
            r_state       <= ST_IDLE;
            r_tank_gnt    <= 1'b0;
            r_mon_gnt     <= '0;
            r_gnt_slot    <= '0;
            r_slot_busy   <= '0;
            r_slot_tank   <= '0;
            r_slot_expire <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_life[i] <= '0;
            end
`ifdef ROUND_ROBIN_EN
            r_rr_ptr      <= MON_W'(NUM_MONSTERS - 1);
`endif
        end else begin
            r_tank_gnt    <= 1'b0;
            r_mon_gnt     <= '0;
            r_gnt_slot    <= '0;
            r_slot_expire <= '0;

            if (i_clear) begin
                r_slot_busy <= '0;
                r_slot_tank <= '0;
                r_state     <= i_enable ? ST_RUN : ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE:  if (i_enable) r_state <= ST_RUN;
                    ST_RUN:   if (!i_enable) r_state <= ST_DRAIN;
                    ST_DRAIN: begin
                        if (i_enable)
                            r_state <= ST_RUN;
                        else if (r_slot_busy == '0)
                            r_state <= ST_IDLE;
                    end
                    default:  r_state <= ST_IDLE;
                endcase

                // A release wins over a coincident expiry and hides its pulse.
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (r_slot_busy[i]) begin
                        if (i_slot_release[i]) begin
                            r_slot_busy[i] <= 1'b0;
                            r_slot_tank[i] <= 1'b0;
                        end else if (w_tick_age && r_life[i] == '0) begin
                            r_slot_busy[i]   <= 1'b0;
                            r_slot_tank[i]   <= 1'b0;
                            r_slot_expire[i] <= 1'b1;
                        end
                        if (w_tick_age && r_life[i] != '0) begin
                            r_life[i] <= r_life[i] - 8'd1;
                        end
                    end
                end

                if (w_do_tank || w_do_mon) begin
                    r_slot_busy[w_free_idx] <= 1'b1;
                    r_slot_tank[w_free_idx] <= w_do_tank;
                    r_life[w_free_idx]      <= 8'(MAX_LIFE);
                    r_gnt_slot              <= w_free_idx;
                end
                if (w_do_tank) begin
                    r_tank_gnt <= 1'b1;
                end
                if (w_do_mon) begin
                    r_mon_gnt[w_mon_idx] <= 1'b1;
`ifdef ROUND_ROBIN_EN
                    r_rr_ptr             <= w_mon_idx;
`endif
                end
            end
        end
    end

    assign o_tank_gnt    = r_tank_gnt;
    assign o_mon_gnt     = r_mon_gnt;
    assign o_gnt_slot    = r_gnt_slot;
    assign o_slot_busy   = r_slot_busy;
    assign o_slot_tank   = r_slot_tank;
    assign o_slot_expire = r_slot_expire;

endmodule

// File: tb/tb_projectile_slot_arbiter.sv
// Bench for projectile_slot_arbiter: directed scenarios plus random traffic against a behavioural slot-pool model.
module tb_projectile_slot_arbiter;

    localparam int NS = 4;
    localparam int NM = 8;
    localparam int ML = 5;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_DRAIN = 2;

    logic          clk = 1'b0;
    logic          rst, tick, en, clr, treq;
    logic [NM-1:0] mreq;
    logic [NS-1:0] rel;
    logic          o_tank_gnt;
    logic [NM-1:0] o_mon_gnt;
    logic [1:0]    o_gnt_slot;
    logic [NS-1:0] o_slot_busy, o_slot_tank, o_slot_expire;

    projectile_slot_arbiter #(.NUM_SLOTS(NS), .NUM_MONSTERS(NM), .MAX_LIFE(ML)) dut (
        .i_clk(clk), .i_rst(rst), .i_frame_tick(tick), .i_enable(en), .i_clear(clr),
        .i_tank_req(treq), .i_mon_req(mreq), .i_slot_release(rel),
        .o_tank_gnt(o_tank_gnt), .o_mon_gnt(o_mon_gnt), .o_gnt_slot(o_gnt_slot),
        .o_slot_busy(o_slot_busy), .o_slot_tank(o_slot_tank), .o_slot_expire(o_slot_expire)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Behavioural model: each slot is a (busy, tank-owned, frames-left) record.
    bit            m_busy [NS];
    bit            m_tank [NS];
    int            m_life [NS];
    int            m_state;
    int            m_rr;
    bit            e_tank_gnt;
    logic [NM-1:0] e_mon_gnt;
    int            e_slot;
    logic [NS-1:0] e_expire;

    function automatic logic [NS-1:0] pack_busy();
        logic [NS-1:0] v = '0;
        for (int i = 0; i < NS; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic logic [NS-1:0] pack_tank();
        logic [NS-1:0] v = '0;
        for (int i = 0; i < NS; i++) v[i] = m_busy[i] && m_tank[i];
        return v;
    endfunction

    task automatic model_step();
        bit tank_out  = 0;
        int free_s    = -1;
        int mon_cnt   = 0;
        int pick      = -1;
        bit give_tank = 0;
        bit any_busy  = 0;
        e_tank_gnt = 0;
        e_mon_gnt  = '0;
        e_expire   = '0;
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                m_busy[i] = 0; m_tank[i] = 0; m_life[i] = 0;
            end
            m_state = S_IDLE;
            m_rr    = NM - 1;
            return;
        end
        if (clr) begin
            for (int i = 0; i < NS; i++) begin
                m_busy[i] = 0; m_tank[i] = 0;
            end
            m_state = en ? S_RUN : S_IDLE;
            return;
        end
        for (int i = 0; i < NS; i++) begin
            if (m_busy[i]) begin
                any_busy = 1;
                if (m_tank[i]) tank_out = 1;
                else mon_cnt++;
            end else if (free_s < 0) begin
                free_s = i;
            end
        end
        if (m_state == S_RUN && tick && free_s >= 0) begin
            if (treq && !tank_out) begin
                give_tank = 1;
            end else if (mreq != '0 && mon_cnt < NS - 1) begin
`ifdef ROUND_ROBIN_EN
                for (int k = 1; k <= NM; k++)
                    if (pick < 0 && mreq[(m_rr + k) % NM]) pick = (m_rr + k) % NM;
`else
                for (int c = 0; c < NM; c++)
                    if (pick < 0 && mreq[c]) pick = c;
`endif
            end
        end
        for (int i = 0; i < NS; i++) begin
            if (m_busy[i]) begin
                if (rel[i]) begin
                    m_busy[i] = 0;
                end else if (tick && m_state != S_IDLE) begin
                    if (m_life[i] == 0) begin
                        m_busy[i]   = 0;
                        e_expire[i] = 1'b1;
                    end else begin
                        m_life[i]--;
                    end
                end
            end
        end
        if (give_tank || pick >= 0) begin
            m_busy[free_s] = 1;
            m_tank[free_s] = give_tank;
            m_life[free_s] = ML;
            e_slot         = free_s;
            e_tank_gnt     = give_tank;
            if (pick >= 0) begin
                e_mon_gnt[pick] = 1'b1;
                m_rr            = pick;
            end
        end
        case (m_state)
            S_IDLE:  if (en) m_state = S_RUN;
            S_RUN:   if (!en) m_state = S_DRAIN;
            default: if (en) m_state = S_RUN; else if (!any_busy) m_state = S_IDLE;
        endcase
    endtask

    // Advance one clock: model consumes the inputs, DUT outputs compared #1 after the edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("tank_gnt", o_tank_gnt, e_tank_gnt);
        check("mon_gnt", o_mon_gnt, e_mon_gnt);
        if (e_tank_gnt || e_mon_gnt != '0) check("gnt_slot", o_gnt_slot, e_slot);
        check("slot_busy", o_slot_busy, pack_busy());
        check("slot_tank", o_slot_tank & o_slot_busy, pack_tank());
        check("slot_expire", o_slot_expire, e_expire);
    endtask

    task automatic tick_once();
        tick = 1'b1;
        cycle();
        tick = 1'b0;
    endtask

    task automatic drop_granted();
        if (e_tank_gnt) treq = 1'b0;
        mreq = mreq & ~e_mon_gnt;
    endtask

    task automatic pulse_rel(input logic [NS-1:0] r);
        rel = r;
        cycle();
        rel = '0;
    endtask

    logic [NM-1:0] exp_seq3 [5];
    logic [NM-1:0] exp_seq4 [3];

    initial begin
        rst = 1'b1; tick = 1'b0; en = 1'b0; clr = 1'b0; treq = 1'b0; mreq = '0; rel = '0;
        cycle();
        check("reset_busy", o_slot_busy, 0);
        check("reset_expire", o_slot_expire, 0);
        rst = 1'b0;
        en  = 1'b1;
        cycle();

        // First tank shot lands in slot 0.
        treq = 1'b1;
        tick_once();
        check("t1_tank_gnt", o_tank_gnt, 1);
        check("t1_slot", o_gnt_slot, 0);
        check("t1_busy", o_slot_busy, 4'b0001);
        check("t1_tank", o_slot_tank, 4'b0001);
        drop_granted();
        cycle();
        check("t1_gnt_pulse", o_tank_gnt, 0);

        // Tank holds its single shot until the slot is released.
        treq = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick_once();
            check("t2_no_regrant", o_tank_gnt, 0);
            cycle();
        end
        pulse_rel(4'b0001);
        check("t2_released", o_slot_busy, 0);
        tick_once();
        check("t2_regrant", o_tank_gnt, 1);
        check("t2_slot", o_gnt_slot, 0);
        drop_granted();
        pulse_rel(4'b0001);

        // Monsters fill three slots, the fourth stays reserved for the tank.
        exp_seq3[0] = 8'h01; exp_seq3[1] = 8'h02; exp_seq3[2] = 8'h04;
        exp_seq3[3] = 8'h00; exp_seq3[4] = 8'h00;
        mreq = 8'hFF;
        for (int n = 0; n < 5; n++) begin
            tick_once();
            check("t3_mon_gnt", o_mon_gnt, exp_seq3[n]);
            if (n < 3) check("t3_slot", o_gnt_slot, n);
            drop_granted();
            cycle();
        end
        treq = 1'b1;
        tick_once();
        check("t3_tank_gnt", o_tank_gnt, 1);
        check("t3_tank_slot", o_gnt_slot, 3);
        drop_granted();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        check("t3_clear", o_slot_busy, 0);

        // Held requests with a release between ticks expose the selection policy.
`ifdef ROUND_ROBIN_EN
        exp_seq4[0] = 8'h08; exp_seq4[1] = 8'h10; exp_seq4[2] = 8'h20;
`else
        exp_seq4[0] = 8'h01; exp_seq4[1] = 8'h01; exp_seq4[2] = 8'h01;
`endif
        mreq = 8'hFF;
        for (int n = 0; n < 3; n++) begin
            tick_once();
            check("t4_mon_gnt", o_mon_gnt, exp_seq4[n]);
            check("t4_slot", o_gnt_slot, 0);
            pulse_rel(4'b0001);
        end
        mreq = '0;

        // Expiry after MAX_LIFE+1 ticks, and release masking a coincident expiry.
        treq = 1'b1;
        tick_once();
        drop_granted();
        cycle();
        for (int n = 1; n <= ML; n++) begin
            tick_once();
            check("t5_no_expire", o_slot_expire, 0);
            check("t5_still_busy", o_slot_busy, 4'b0001);
            cycle();
        end
        tick_once();
        check("t5_expire", o_slot_expire, 4'b0001);
        check("t5_freed", o_slot_busy, 0);
        cycle();
        check("t5_expire_pulse", o_slot_expire, 0);
        treq = 1'b1;
        tick_once();
        drop_granted();
        cycle();
        for (int n = 1; n <= ML; n++) begin
            tick_once();
            cycle();
        end
        tick = 1'b1; rel = 4'b0001;
        cycle();
        tick = 1'b0; rel = '0;
        check("t5_rel_masks", o_slot_expire, 0);
        check("t5_rel_freed", o_slot_busy, 0);

        // Drain: no grants while disabled, aging/releases continue, clear empties the pool.
        treq = 1'b1;
        tick_once();
        drop_granted();
        cycle();
        mreq = 8'h01;
        tick_once();
        drop_granted();
        cycle();
        check("t6_two_busy", o_slot_busy, 4'b0011);
        en = 1'b0;
        cycle();
        mreq = 8'hFF; treq = 1'b1;
        for (int n = 0; n < 2; n++) begin
            tick_once();
            check("t6_drain_no_mon", o_mon_gnt, 0);
            check("t6_drain_no_tank", o_tank_gnt, 0);
            cycle();
        end
        pulse_rel(4'b0011);
        check("t6_drained", o_slot_busy, 0);
        cycle();
        en = 1'b1;
        cycle();
        tick_once();
        check("t6_rerun_tank", o_tank_gnt, 1);
        drop_granted();
        en = 1'b0;
        cycle();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        check("t6_clear_drain", o_slot_busy, 0);
        tick_once();
        check("t6_idle_no_gnt", o_mon_gnt, 0);
        mreq = '0; treq = 1'b0;
        en = 1'b1;

        // Random traffic: sticky requests, sporadic ticks, releases, clears, enables and resets.
        for (int n = 0; n < 4000; n++) begin
            rst  = ($urandom_range(499, 0) == 0);
            clr  = ($urandom_range(99, 0) == 0);
            tick = ($urandom_range(2, 0) == 0);
            if ($urandom_range(59, 0) == 0) en = ~en;
            for (int i = 0; i < NS; i++) rel[i] = ($urandom_range(29, 0) == 0);
            if (!treq && $urandom_range(5, 0) == 0) treq = 1'b1;
            else if (treq && $urandom_range(49, 0) == 0) treq = 1'b0;
            for (int i = 0; i < NM; i++) begin
                if (!mreq[i] && $urandom_range(9, 0) == 0) mreq[i] = 1'b1;
                else if (mreq[i] && $urandom_range(49, 0) == 0) mreq[i] = 1'b0;
            end
            cycle();
            drop_granted();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
